// File: rtl/digtal_tx_frame.sv
// Framed 8N1 transmitter: buffers bytes in a FIFO, sends header + Payload_Length bytes per CS rising edge.
// Tx falls 2 edges after CS is first sampled high; writes while full are dropped, requests without enough data are refused.
module digtal_tx_frame #(
  parameter int         CLOCK_Frequency = 29491200,
  parameter int         BAUD_Digtal     = 921600,
  parameter int         Instert_Length  = 4,
  parameter logic [7:0] Instert_Byte1   = 8'hEB,
  parameter logic [7:0] Instert_Byte2   = 8'h90,
  parameter logic [7:0] Instert_Byte3   = 8'h90,
  parameter logic [7:0] Instert_Byte4   = 8'hEB,
  parameter logic [7:0] Instert_Byte5   = 8'hEB,
  parameter logic [7:0] Instert_Byte6   = 8'h90,
  parameter logic [7:0] Instert_Byte7   = 8'h90,
  parameter logic [7:0] Instert_Byte8   = 8'hEB,
  parameter int         Payload_Length  = 256,
  parameter int         FIFO_AW         = 12
) (
  input  logic               CLOCK_Digtal,
  input  logic               Reset_n,
  input  logic               WR,
  input  logic [7:0]         Wr_Data,
  input  logic               CS,
  output logic               Tx,
  output logic               Busy,
  output logic               Full,
  output logic [FIFO_AW:0]   Count,
  output logic               Drop,
  output logic               Frame_Err
);

  localparam int BIT_DIV = CLOCK_Frequency / BAUD_Digtal;
  localparam int DIVW    = $clog2(BIT_DIV + 1);
  localparam int CW      = FIFO_AW + 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BIT_DIV - 1);
  localparam logic [CW-1:0]   PAY_LEN  = CW'(Payload_Length);
  localparam logic [CW-1:0]   PAY_LAST = CW'(Payload_Length - 1);
  localparam logic [CW-1:0]   HDR_LAST = CW'(Instert_Length - 1);
  localparam logic [63:0]     HDR_BYTES = {Instert_Byte8, Instert_Byte7, Instert_Byte6, Instert_Byte5,
                                           Instert_Byte4, Instert_Byte3, Instert_Byte2, Instert_Byte1};

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  state_t              state_q, state_d;
  logic [DIVW-1:0]     div_q, div_d;
  logic [3:0]          bit_q, bit_d;
  logic [CW-1:0]       byte_q, byte_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                ferr_q, ferr_d;
  logic                drop_q, drop_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic                cs_s1_q, cs_s1_d;
  logic                cs_s2_q, cs_s2_d;
  logic                cs_s3_q, cs_s3_d;

  logic [7:0]          mem [0:(1<<FIFO_AW)-1];
  logic [7:0]          rd_dat;
  logic                full, push, pop, cs_rise;
  logic [2:0]          nxt_hdr;

  assign full    = cnt_q[FIFO_AW];
  assign push    = WR & ~full;
  assign cs_rise = cs_s2_q & ~cs_s3_q;
  assign rd_dat  = mem[rd_ptr_q];

  always_ff @(posedge CLOCK_Digtal) begin
    if (push) mem[wr_ptr_q] <= Wr_Data;
  end

  always_comb begin
    cs_s1_d  = CS;
    cs_s2_d  = cs_s1_q;
    cs_s3_d  = cs_s2_q;
    drop_d   = WR & full;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ferr_d  = 1'b0;
    pop     = 1'b0;
    nxt_hdr = byte_q[2:0] + 3'd1;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (cs_rise) begin
          if (cnt_q >= PAY_LEN) begin
            busy_d = 1'b1;
            tx_d   = 1'b0;
            div_d  = '0;
            bit_d  = '0;
            byte_d = '0;
            if (Instert_Length == 0) begin
              state_d = S_PAY;
              pop     = 1'b1;
              shreg_d = rd_dat;
            end else begin
              state_d = S_HDR;
              shreg_d = HDR_BYTES[7:0];
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (bit_q != 4'd9) begin
            // bit_q 0..7 -> next is data bit bit_q, bit_q 8 -> next is stop
            bit_d = bit_q + 4'd1;
            tx_d  = (bit_q == 4'd8) ? 1'b1 : shreg_q[bit_q[2:0]];
          end else begin
            bit_d  = '0;
            tx_d   = 1'b0;
            byte_d = byte_q + 1'b1;
            if (state_q == S_HDR) begin
              if (byte_q == HDR_LAST) begin
                state_d = S_PAY;
                byte_d  = '0;
                pop     = 1'b1;
                shreg_d = rd_dat;
              end else begin
                shreg_d = HDR_BYTES[{nxt_hdr, 3'b000} +: 8];
              end
            end else if (byte_q == PAY_LAST) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end else begin
              pop     = 1'b1;
              shreg_d = rd_dat;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_Digtal or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      drop_q   <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cs_s1_q  <= 1'b0;
      cs_s2_q  <= 1'b0;
      cs_s3_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cs_s1_q  <= cs_s1_d;
      cs_s2_q  <= cs_s2_d;
      cs_s3_q  <= cs_s3_d;
    end
  end

  assign Tx        = tx_q;
  assign Busy      = busy_q;
  assign Full      = full;
  assign Count     = cnt_q;
  assign Drop      = drop_q;
  assign Frame_Err = ferr_q;

endmodule

// File: tb/tb_digtal_tx_frame.sv
// Bench for digtal_tx_frame: queue model of the FIFO, UART-decoding monitor fed from an expected-byte scoreboard.
module tb_digtal_tx_frame;
  localparam int BD        = 32;
  localparam int HL        = 4;
  localparam int PL        = 4;
  localparam int AW        = 12;
  localparam int DEPTH     = 4096;
  localparam int PERIOD    = 10;
  localparam int FRAME_CLK = (HL + PL) * 10 * BD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic          cs = 1'b0;
  logic [7:0]    wr_dat = 8'h00;
  logic          tx, busy, full, drop, ferr;
  logic [AW:0]   count;

  always #(PERIOD/2) clk = ~clk;

  digtal_tx_frame #(
    .CLOCK_Frequency(29491200),
    .BAUD_Digtal    (921600),
    .Instert_Length (HL),
    .Payload_Length (PL),
    .FIFO_AW        (AW)
  ) dut (
    .CLOCK_Digtal(clk),
    .Reset_n     (rst_n),
    .WR          (wr),
    .Wr_Data     (wr_dat),
    .CS          (cs),
    .Tx          (tx),
    .Busy        (busy),
    .Full        (full),
    .Count       (count),
    .Drop        (drop),
    .Frame_Err   (ferr)
  );

  int         total = 0;
  int         bad = 0;
  int         epoch = 0;
  bit         new_frame = 1'b0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] hdr_tab [0:3] = '{8'hEB, 8'h90, 8'h90, 8'hEB};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    bit exp_drop;
    exp_drop = (model_q.size() == DEPTH);
    if (!exp_drop) model_q.push_back(d);
    wr = 1'b1;
    wr_dat = d;
    tick();
    wr = 1'b0;
    chk("drop", 32'(drop), 32'(exp_drop));
    chk("count_wr", 32'(count), model_q.size());
  endtask

  // rst_at: busy-cycle index at which reset is applied mid-frame (0 = none)
  task automatic do_frame(input int rst_at, input bit extra);
    bit ok;
    int n;
    int cb;
    ok = (model_q.size() >= PL);
    new_frame = 1'b1;
    cs = 1'b1;
    tick();
    chk("k_tx", 32'(tx), 1);
    tick();
    chk("k1_busy", 32'(busy), 0);
    chk("k1_ferr", 32'(ferr), 0);
    tick();
    if (!ok) begin
      chk("refuse_ferr", 32'(ferr), 1);
      chk("refuse_busy", 32'(busy), 0);
      cs = 1'b0;
      tick();
      chk("ferr_pulse_end", 32'(ferr), 0);
      repeat (8) begin
        tick();
        chk("refuse_tx_idle", 32'(tx), 1);
      end
      chk("refuse_count", 32'(count), model_q.size());
      return;
    end
    chk("start_tx", 32'(tx), 0);
    chk("start_busy", 32'(busy), 1);
    chk("start_ferr", 32'(ferr), 0);
    for (int i = 0; i < HL; i++) exp_q.push_back(hdr_tab[i]);
    repeat (PL) exp_q.push_back(model_q.pop_front());
    n = 0;
    cb = 0;
    while (busy === 1'b1 && n < FRAME_CLK + 100) begin
      if (n == 20) cs = 1'b0;
      if (extra) begin
        if (n == 200) cs = 1'b1;
        if (n == 300) cs = 1'b0;
        if (n + 1 == HL * 10 * BD) begin
          wr = 1'b1;
          wr_dat = 8'($urandom);
          model_q.push_back(wr_dat);
          cb = int'(count);
        end
      end
      if (rst_at != 0 && n == rst_at) begin
        cs = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(tx), 1);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_count", 32'(count), 0);
        model_q.delete();
        exp_q.delete();
        epoch++;
        tick();
        tick();
        rst_n = 1'b1;
        return;
      end
      tick();
      n++;
      if (wr) begin
        chk("wr_pop_count", 32'(count), cb);
        wr = 1'b0;
      end
    end
    chk("busy_len", n, FRAME_CLK);
    chk("end_tx", 32'(tx), 1);
    chk("end_count", 32'(count), model_q.size());
    cs = 1'b0;
  endtask

  // UART decoder: samples each bit mid-period and scores against exp_q
  initial begin
    logic [7:0] b;
    logic       st, sp;
    int         ep, prev_ep;
    time        t_prev;
    bit         have_prev;
    have_prev = 1'b0;
    prev_ep = 0;
    t_prev = 0;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge tx);
      ep = epoch;
      if (!new_frame && have_prev && ep == prev_ep)
        chk("byte_gap", 32'($time - t_prev), 10 * BD * PERIOD);
      new_frame = 1'b0;
      t_prev = $time;
      have_prev = 1'b1;
      prev_ep = ep;
      repeat (BD/2) @(posedge clk);
      #1 st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(posedge clk);
        #1 b[i] = tx;
      end
      repeat (BD) @(posedge clk);
      #1 sp = tx;
      if (ep != epoch) continue;
      chk("start_bit", 32'(st), 0);
      chk("stop_bit", 32'(sp), 1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h want none", b);
      end else begin
        chk("byte", 32'(b), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #(100000 * PERIOD);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (20) begin
      wr = 1'($urandom);
      wr_dat = 8'($urandom);
      cs = 1'($urandom);
      tick();
      chk("rst_tx", 32'(tx), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_drop", 32'(drop), 0);
      chk("rst_ferr", 32'(ferr), 0);
    end
    wr = 1'b0;
    cs = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();

    wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44);
    do_frame(0, 1'b0);

    repeat (3) wr_byte(8'($urandom));
    do_frame(0, 1'b0);

    repeat (5) wr_byte(8'($urandom));
    do_frame(0, 1'b1);
    repeat (20) tick();
    chk("no_extra_frame", 32'(busy), 0);

    repeat (4) begin
      repeat ($urandom_range(0, 6)) wr_byte(8'($urandom));
      do_frame(0, 1'b0);
      repeat ($urandom_range(1, 30)) tick();
    end

    while (model_q.size() < PL) wr_byte(8'($urandom));
    do_frame(HL * 10 * BD + 500, 1'b0);
    repeat (400) tick();
    chk("post_rst_tx", 32'(tx), 1);
    chk("post_rst_count", 32'(count), 0);
    repeat (4) wr_byte(8'($urandom));
    do_frame(0, 1'b0);

    for (int i = 0; i < DEPTH; i++) wr_byte(8'($urandom));
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(count), DEPTH);
    wr_byte(8'hA5);
    chk("full_after_drop", 32'(full), 1);
    tick();
    chk("drop_one_cycle", 32'(drop), 0);
    do_frame(0, 1'b0);
    chk("unfull", 32'(full), 0);

    repeat (BD * 12) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
